// File: rtl/parity_frame_pkg.sv
// Shared definitions for the parity frame link: state encodings, frame geometry
// and the odd-parity convention, reused by the transmitter and the future receiver.
package parity_frame_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int unsigned FRAME_BITS = 6;
  localparam int unsigned DATA_BITS  = 3;

  // Parity bit makes the count of ones over data+parity odd.
  localparam logic PARITY_ODD = 1'b1;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StStart  = ST_START,
    StData   = ST_DATA,
    StParity = ST_PARITY,
    StStop   = ST_STOP
  } frame_state_e;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/parity3_odd.sv
// Combinational 3-input odd-parity generator: f is set when a, b, c hold an even
// number of ones, so {a, b, c, f} always has odd weight.
module parity3_odd (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f
);

  assign f = ~(a ^ b ^ c);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, three data bits LSB first, odd parity, stop,
// each bit held CLKS_PER_BIT cycles on an idle-high line.
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  // tx is registered from the state, so STOP holds one extra cycle to let the
  // stop bit play out fully before IDLE.
  localparam logic [TW-1:0] STOP_LAST = TW'(CLKS_PER_BIT);

  frame_state_e          state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [1:0]            idx_q, idx_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  tx_d, done_d;
  logic                  par_bit;
  logic                  bit_end;

  parity3_odd u_parity (
    .a (in_data[0]),
    .b (in_data[1]),
    .c (in_data[2]),
    .f (par_bit)
  );

  assign in_ready = (state_q == StIdle) && !reset;
  assign bit_end  = (timer_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          shreg_d = in_data;
          par_d   = par_bit;
          timer_d = '0;
          idx_d   = 2'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          timer_d = '0;
          idx_d   = 2'd0;
          state_d = StData;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StData: begin
        tx_d = shreg_q[0];
        if (bit_end) begin
          timer_d = '0;
          shreg_d = shreg_q >> 1;
          if (idx_q == 2'(DATA_BITS - 1)) begin
            state_d = StParity;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StParity: begin
        tx_d = par_q;
        if (bit_end) begin
          timer_d = '0;
          state_d = StStop;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (timer_q == STOP_LAST) begin
          timer_d = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= 2'd0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx      <= tx_d;
      done    <= done_d;
      busy    <= (state_d != StIdle);
    end
  end

endmodule
